// File: rtl/pc_branch_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_branch_unit_pkg
// Shared constants and types for the program-counter stage and its helpers.
//   DEF_PC_W      : default PC / branch-offset width
//   DEF_RESET_PC  : default PC value loaded on reset
//   DEF_CNT_W     : default retired-instruction counter width
//   pc_state_e    : RUN / HALT state of the PC sequencer
// ---------------------------------------------------------------------------
package pc_branch_unit_pkg;

    localparam int         DEF_PC_W     = 8;
    localparam logic [7:0] DEF_RESET_PC = 8'h00;
    localparam int         DEF_CNT_W    = 16;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_e;

endpackage : pc_branch_unit_pkg

// File: rtl/pc_branch_unit_branch_target_calc.sv
// ---------------------------------------------------------------------------
// branch_target_calc
// Combinational PC arithmetic shared by the branch unit and the jump/call
// unit. All arithmetic is modulo 2^PC_W; the offset is two's complement, so
// adding it at PC_W bits gives forward and backward targets with silent wrap.
// Ports:
//   i_pc           : current PC
//   i_extended_off : sign-extended branch offset
//   o_pc_plus1     : sequential successor of i_pc
//   o_br_target    : i_pc + 1 + i_extended_off
// ---------------------------------------------------------------------------
module branch_target_calc #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_extended_off,
    output logic [PC_W-1:0] o_pc_plus1,
    output logic [PC_W-1:0] o_br_target
);

    logic [PC_W-1:0] w_pc_plus1;

    // Sequential successor, truncated to PC_W bits so FF wraps to 00.
    always_comb begin
        w_pc_plus1 = i_pc + PC_W'(1);
    end

    // PC-relative target; two's-complement add handles negative offsets.
    always_comb begin
        o_pc_plus1  = w_pc_plus1;
        o_br_target = w_pc_plus1 + i_extended_off;
    end

endmodule : branch_target_calc

// File: rtl/pc_branch_unit.sv
// ---------------------------------------------------------------------------
// pc_branch_unit
// Program-counter stage of the 8-bit datapath. Each cycle the PC advances
// sequentially, jumps to a taken PC-relative branch target, or holds for a
// stall or HALT. Every output is registered; nothing combinational reaches
// an output from an input.
// Ports:
//   clk          : system clock, rising edge
//   reset        : synchronous active-high reset, overrides everything
//   stall        : hold all state this cycle
//   br, br_cond  : branch instruction / branch condition true
//   extended_off : sign-extended branch offset (PC_W bits)
//   halt         : current instruction is HALT
//   resume       : leave HALT state
//   pc           : address of the instruction being fetched
//   flush        : one-cycle pulse while pc first shows a taken target
//   halted       : high while in HALT state
//   instr_count  : retired instructions, saturating at all-ones
// ---------------------------------------------------------------------------
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
    parameter int              CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br,
    input  logic             br_cond,
    input  logic [PC_W-1:0]  extended_off,
    input  logic             halt,
    input  logic             resume,
    output logic [PC_W-1:0]  pc,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    pc_state_e        r_state;
    pc_state_e        w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic             r_flush;
    logic             w_flush_nxt;
    logic             r_halted;
    logic             w_halted_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_retire;
    logic [PC_W-1:0]  w_pc_plus1;
    logic [PC_W-1:0]  w_br_target;

    branch_target_calc #(
        .PC_W (PC_W)
    ) u_target (
        .i_pc           (r_pc),
        .i_extended_off (extended_off),
        .o_pc_plus1     (w_pc_plus1),
        .o_br_target    (w_br_target)
    );

    // State and output registers; synchronous reset wins over all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_pc     <= RESET_PC;
            r_flush  <= 1'b0;
            r_halted <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_flush  <= w_flush_nxt;
            r_halted <= w_halted_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Next-state logic: stall blocks both entering and leaving HALT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (!stall && halt) begin
                    w_state_nxt = HALT;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            HALT: begin
                if (resume && !stall) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = HALT;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Output logic: next PC, flush and retire strobe.
    // In RUN the priority is stall > halt > taken branch > sequential; a
    // halt retires and steps past itself so resume fetches the next opcode.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_flush_nxt = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            RUN: begin
                if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (halt) begin
                    w_pc_nxt = w_pc_plus1;
                    w_retire = 1'b1;
                end else if (br && br_cond) begin
                    w_pc_nxt    = w_br_target;
                    w_flush_nxt = 1'b1;
                    w_retire    = 1'b1;
                end else begin
                    w_pc_nxt = w_pc_plus1;
                    w_retire = 1'b1;
                end
            end
            HALT: begin
                w_pc_nxt = r_pc;
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
        w_halted_nxt = (w_state_nxt == HALT);
    end

    // Saturating retired-instruction counter: sticks at all-ones.
    always_comb begin
        if (w_retire && (r_cnt != {CNT_W{1'b1}})) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Drive ports straight from registers.
    always_comb begin
        pc          = r_pc;
        flush       = r_flush;
        halted      = r_halted;
        instr_count = r_cnt;
    end

endmodule : pc_branch_unit

// File: tb/tb_pc_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_branch_unit
// Scoreboard bench: the driver applies stimulus on the falling edge and
// pushes the expected post-edge outputs from an arithmetic reference model;
// a monitor pops and compares shortly after each rising edge. A second
// instance with a 4-bit counter shares the stimulus to exercise saturation.
// ---------------------------------------------------------------------------
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic        br_cond = 1'b0;
    logic [7:0]  extended_off = 8'h00;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [7:0]  pc;
    logic        flush;
    logic        halted;
    logic [15:0] instr_count;
    logic [7:0]  pc4;
    logic        flush4;
    logic        halted4;
    logic [3:0]  instr_count4;

    always #5 clk = ~clk;

    pc_branch_unit dut (
        .clk (clk), .reset (reset), .stall (stall), .br (br),
        .br_cond (br_cond), .extended_off (extended_off), .halt (halt),
        .resume (resume), .pc (pc), .flush (flush), .halted (halted),
        .instr_count (instr_count)
    );

    pc_branch_unit #(.CNT_W (4)) dut4 (
        .clk (clk), .reset (reset), .stall (stall), .br (br),
        .br_cond (br_cond), .extended_off (extended_off), .halt (halt),
        .resume (resume), .pc (pc4), .flush (flush4), .halted (halted4),
        .instr_count (instr_count4)
    );

    typedef struct {
        int pc;
        int flush;
        int halted;
        int cnt;
        int cnt4;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (plain integers).
    int m_pc = 0;
    int m_halted = 0;
    int m_flush = 0;
    int m_cnt = 0;
    int m_cnt4 = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and predict the outputs after the edge.
    task automatic cyc(input bit rst, input bit st, input bit b, input bit bc,
                       input logic [7:0] off, input bit h, input bit res);
        exp_t e;
        int   soff;
        @(negedge clk);
        reset = rst; stall = st; br = b; br_cond = bc;
        extended_off = off; halt = h; resume = res;
        soff = int'($signed(off));
        if (rst) begin
            m_pc = 0; m_halted = 0; m_flush = 0; m_cnt = 0; m_cnt4 = 0;
        end else if (m_halted != 0) begin
            m_flush = 0;
            if (res && !st) m_halted = 0;
        end else if (st) begin
            m_flush = 0;
        end else begin
            if (h) begin
                m_pc = (m_pc + 1) % 256;
                m_halted = 1;
                m_flush = 0;
            end else if (b && bc) begin
                m_pc = (m_pc + 1 + soff) & 255;
                m_flush = 1;
            end else begin
                m_pc = (m_pc + 1) % 256;
                m_flush = 0;
            end
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        e.pc = m_pc; e.flush = m_flush; e.halted = m_halted;
        e.cnt = m_cnt; e.cnt4 = m_cnt4;
        q.push_back(e);
    endtask

    task automatic seq();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Taken branch whose target is the requested pc.
    task automatic to_pc(input int t);
        logic [7:0] o;
        o = 8'((t - m_pc - 1) & 255);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, o, 1'b0, 1'b0);
    endtask

    // Monitor: one expected record per rising edge once stimulus started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", int'(pc), e.pc);
                chk("flush", int'(flush), e.flush);
                chk("halted", int'(halted), e.halted);
                chk("instr_count", int'(instr_count), e.cnt);
                chk("instr_count4", int'(instr_count4), e.cnt4);
                chk("pc4", int'(pc4), e.pc);
            end
        end
    end

    initial begin
        int w;
        // 1: reset then three idle cycles.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) seq();
        // 2: taken branch at pc=03 with -4, then not-taken at pc=03.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hFC, 1'b0, 1'b0);
        repeat (3) seq();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFC, 1'b0, 1'b0);
        // 3: wrap-around forward and sequential past FF.
        to_pc(8'hFE);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
        to_pc(8'hFF);
        seq();
        // Offset 0 and back-to-back taken branches.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0);
        // 4: stall four cycles with a taken branch pending.
        repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        // 5: halt with br at pc=05, ignored br/halt while halted, resume.
        to_pc(8'h05);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b0, i[0], 1'b1, 8'h20, i[1], 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        seq();
        // 6: reach count 40 on a halt, reset while halted, then saturate.
        while (m_cnt < 39) seq();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (2) seq();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (20) seq();
        // Reset during a stall.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(99) < 2, $urandom_range(99) < 20,
                $urandom_range(99) < 45, $urandom_range(1) == 1,
                8'($urandom_range(255)), $urandom_range(99) < 6,
                $urandom_range(99) < 30);
        end
        // Drain the scoreboard with a bounded wait.
        w = 0;
        while (q.size() > 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pc_branch_unit

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
Program-counter stage of the 8-bit datapath. It sits directly downstream of the sign-extension unit: it consumes the sign-extended branch offset and the branch flag, and each cycle updates the PC sequentially, by a taken PC-relative branch, or holds it for a stall or halt. It also produces a pipeline-flush pulse, a halted status and a retired-instruction counter for the fetch/decode stages and the debug display.

Parameters:
PC_W, 8, PC and offset width; extended_off is PC_W bits
RESET_PC, 8'h00, PC value loaded on reset
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold all state this cycle (memory/hazard stall)
br  in  1  current instruction is a branch (same br given to sign extension)
br_cond  in  1  branch condition true (e.g. zero flag)
extended_off  in  PC_W  sign-extended two's-complement branch offset
halt  in  1  current instruction is HALT
resume  in  1  leave HALT state
pc  out  PC_W  address of the instruction being fetched
flush  out  1  high for exactly the cycle pc first shows a taken-branch target
halted  out  1  high while in HALT state
instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset, synchronous and active-high, is evaluated at the clock edge and overrides everything. Outputs after reset: pc=RESET_PC, state=RUN, flush=0, halted=0, instr_count=0.
- FSM has two states, RUN and HALT. halted is a registered output equal to (state==HALT).
- In RUN, priority is stall > halt > taken branch > sequential.
  - stall=1: pc, state and instr_count are held; flush=0 next cycle.
  - halt=1: pc<=pc+1; state<=HALT; instr_count increments. halt wins over a simultaneous br.
  - br=1 and br_cond=1: pc<=pc+1+extended_off; flush<=1; instr_count increments.
  - br=1 and br_cond=0: treated as sequential.
  - otherwise: pc<=pc+1; flush<=0; instr_count increments.
- In HALT:
  - pc and instr_count are held; flush=0.
  - br and halt are ignored.
  - resume=1 and stall=0: state<=RUN. pc is unchanged, so fetch continues at the instruction after HALT.
  - resume=1 and stall=1: state stays HALT.
- Arithmetic: all PC math is modulo 2^PC_W, and wrap-around is silent in both directions.
  - extended_off is treated as signed. Target = pc+1+offset, so offset 0 behaves like sequential but still asserts flush.
- flush is registered. It is high for one cycle, coincident with pc holding the target. Back-to-back taken branches keep flush high on consecutive cycles.
- instr_count saturates at all-ones and never wraps.
- Latency: pc updates one cycle after the inputs are sampled. The unit has no combinational path from inputs to outputs.
- Reset during HALT or mid-stall returns to RUN with pc=RESET_PC on the next edge.

Decomposition:
- A shared package holds:
  - PC_W default constant
  - RESET_PC constant
  - state typedef with enum values RUN and HALT
- One sub-module is natural: branch_target_calc, combinational. It takes pc and extended_off and produces pc_plus1 and br_target. It is reused later by the jump/call unit.
- The FSM, PC register, flush register and counter stay in pc_branch_unit.

Test Plan:
1. Reset, then 3 idle RUN cycles -> pc=0,1,2,3; instr_count=3; flush=0; halted=0.
2. Taken branch at pc=8'h03 with extended_off=8'hFC (-4) -> next pc=8'h00, flush=1 for that cycle only. Same stimulus with br_cond=0 -> pc=8'h04, flush=0.
3. Wrap-around: pc=8'hFE, taken branch, extended_off=8'h03 -> pc=8'h02. Sequential from pc=8'hFF -> 8'h00.
4. Stall held 4 cycles during a taken-branch request -> pc and instr_count frozen, no flush. The branch takes effect on the first cycle after stall drops.
5. halt with br=1 at pc=8'h05 -> pc=8'h06, halted=1. pc held 10 cycles despite br pulses. resume with stall=1 -> still halted. resume with stall=0 -> halted=0 next cycle, then pc=8'h07.
6. Reset asserted while halted with instr_count=40 -> next edge pc=8'h00, instr_count=0, halted=0, flush=0. With CNT_W=4, 20 cycles -> count saturates at 4'hF.
